// File: rtl/tdm_demux_if.sv
// tdm_demux_if: slot-stream and frame-output bundle for the TDM demultiplexer.
//   d, valid_in, sof        slot stream from the link (driven by master)
//   y, frame_valid,         captured frame and status pulses (driven by slave)
//   frame_err, s
interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int CNT_W    = 2
);
  logic [WIDTH-1:0]          d;
  logic                      valid_in;
  logic                      sof;
  logic [CHANNELS*WIDTH-1:0] y;
  logic                      frame_valid;
  logic                      frame_err;
  logic [CNT_W-1:0]          s;

  modport master (
    output d, valid_in, sof,
    input  y, frame_valid, frame_err, s
  );

  modport slave (
    input  d, valid_in, sof,
    output y, frame_valid, frame_err, s
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: receiving end of a TDM link. Collects CHANNELS consecutive slots,
// sof marking slot 0, into a shadow register and publishes the complete frame on y.
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus.d        slot data           bus.valid_in  slot strobe
//   bus.sof      start of frame      bus.y         last complete frame (ch i at y[i*WIDTH +: WIDTH])
//   bus.frame_valid  pulse: y updated on previous edge
//   bus.frame_err    pulse: short frame discarded
//   bus.s            index of next expected slot (0 when idle)
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int CNT_W    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  tdm_demux_if.slave bus
);

  localparam int unsigned LAST = CHANNELS - 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          s_q, s_d;
  logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS*WIDTH-1:0] y_q, y_d;
  logic                      fv_q, fv_d;
  logic                      fe_q, fe_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      fv_q     <= fv_d;
      fe_q     <= fe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Slots without sof while idle are stray tail slots; silently dropped.
        if (bus.valid_in && bus.sof) begin
          shadow_d[WIDTH-1:0] = bus.d;
          if (CHANNELS == 1) begin
            y_d[WIDTH-1:0] = bus.d;
            fv_d           = 1'b1;
          end else begin
            s_d     = CNT_W'(1);
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (bus.valid_in) begin
          if (bus.sof) begin
            // Early sof: abandon the partial frame, restart with this slot as slot 0.
            fe_d                = 1'b1;
            shadow_d[WIDTH-1:0] = bus.d;
            s_d                 = CNT_W'(1);
          end else if (s_q == CNT_W'(LAST)) begin
            // Last slot bypasses the shadow and goes straight into y.
            y_d                          = shadow_q;
            y_d[LAST*WIDTH +: WIDTH]     = bus.d;
            fv_d                         = 1'b1;
            s_d                          = '0;
            state_d                      = IDLE;
          end else begin
            for (int unsigned i = 1; i < LAST; i++) begin
              if (s_q == CNT_W'(i)) shadow_d[i*WIDTH +: WIDTH] = bus.d;
            end
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
  end

  assign bus.y           = y_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;
  assign bus.s           = s_q;

endmodule
